// File: rtl/fetch_unit_pkg.sv
// Shared types for the fetch stage: redirect type codes, FSM states, buffer depth and the
// branch-taken rule.
package fetch_unit_pkg;

   typedef enum logic [2:0] {
      JNop  = 3'b000,
      JBeq  = 3'b001,
      JJal  = 3'b010,
      JJr   = 3'b011,
      JJmp  = 3'b100,
      JBodd = 3'b101
   } redir_type_e;

   typedef enum logic [1:0] {
      StReq  = 2'b00,
      StWait = 2'b01,
      StFull = 2'b10
   } fetch_state_e;

   localparam int unsigned BufDepth = 2;

   function automatic logic redir_taken(logic [2:0] rtype, logic operands_eq, logic rs1_odd);
      logic tk;
      tk = 1'b0;
      case (rtype)
         JBeq:             tk = operands_eq;
         JBodd:            tk = rs1_odd;
         JJal, JJr, JJmp:  tk = 1'b1;
         default:          tk = 1'b0;
      endcase
      return tk;
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: imem request/response, instruction hand-off to decode and decode-side redirect.
// master = fetch unit, slave = the imem/decode environment around it.
interface fetch_unit_if #(
   parameter int unsigned DWIDTH = 32
);
   logic              imem_req_valid;
   logic              imem_req_ready;
   logic [DWIDTH-1:0] imem_req_addr;
   logic              imem_rsp_valid;
   logic [DWIDTH-1:0] imem_rsp_data;
   logic              instr_valid;
   logic              instr_ready;
   logic [DWIDTH-1:0] instr;
   logic [DWIDTH-1:0] instr_pc4;
   logic              redir_valid;
   logic [2:0]        redir_type;
   logic [DWIDTH-1:0] redir_pc4;
   logic [DWIDTH-1:0] redir_imm;
   logic [DWIDTH-1:0] redir_addr;
   logic [DWIDTH-1:0] redir_rs1;
   logic [DWIDTH-1:0] redir_rs2;

   modport master (
      output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc4,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
      input  redir_valid, redir_type, redir_pc4, redir_imm, redir_addr, redir_rs1, redir_rs2
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc4,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
      output redir_valid, redir_type, redir_pc4, redir_imm, redir_addr, redir_rs1, redir_rs2
   );
endinterface

// File: rtl/fetch_unit_buf.sv
// Two-entry {instr, pc4} output FIFO; entry 0 is always the head so outputs come straight from
// registers. Flush wins over push/pop in the same cycle.
module fetch_unit_buf
   import fetch_unit_pkg::*;
#(
   parameter int unsigned DWIDTH = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DWIDTH-1:0] push_instr,
   input  logic [DWIDTH-1:0] push_pc4,
   input  logic              pop,
   input  logic              flush,
   output logic [DWIDTH-1:0] head_instr,
   output logic [DWIDTH-1:0] head_pc4,
   output logic              head_valid,
   output logic [1:0]        count
);

   logic [DWIDTH-1:0] instr_q [2];
   logic [DWIDTH-1:0] instr_d [2];
   logic [DWIDTH-1:0] pc4_q   [2];
   logic [DWIDTH-1:0] pc4_d   [2];
   logic [1:0]        count_q, count_d, base;
   logic              pop_ok, push_ok;

   always_comb begin
      instr_d = instr_q;
      pc4_d   = pc4_q;
      count_d = count_q;
      pop_ok  = pop & (count_q != 2'd0);
      push_ok = push & ((count_q != 2'(BufDepth)) | pop_ok);
      // Write slot is the occupancy left after this cycle's pop has shifted the head.
      base    = count_q - {1'b0, pop_ok};
      if (flush) begin
         count_d = '0;
      end else begin
         if (pop_ok) begin
            instr_d[0] = instr_q[1];
            pc4_d[0]   = pc4_q[1];
         end
         if (push_ok) begin
            instr_d[base[0]] = push_instr;
            pc4_d[base[0]]   = push_pc4;
         end
         count_d = base + {1'b0, push_ok};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q <= '{default: '0};
         pc4_q   <= '{default: '0};
         count_q <= '0;
      end else begin
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         count_q <= count_d;
      end
   end

   assign head_instr = instr_q[0];
   assign head_pc4   = pc4_q[0];
   assign head_valid = (count_q != 2'd0);
   assign count      = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, single-outstanding imem request FSM, 2-entry decode buffer and
// redirect handling. Define FETCH_PERF_EN to add fetched/dropped/redirect counters.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int unsigned       DWIDTH   = 32,
   parameter logic [DWIDTH-1:0] RESET_PC = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]  perf_fetched,
   output logic [31:0]  perf_dropped,
   output logic [31:0]  perf_redirects
`endif
);

   fetch_state_e      state_q, state_d;
   logic [DWIDTH-1:0] pc_q, pc_d, req_addr_q, target;
   logic              req_valid_q, drop_q, drop_d;
   logic              taken, req_fire, rsp_in, push, pop, slot_free;
   logic [1:0]        count, count_after;

   assign req_fire    = req_valid_q & bus.imem_req_ready;
   assign rsp_in      = (state_q == StWait) & bus.imem_rsp_valid;
   assign taken       = bus.redir_valid &
                        redir_taken(bus.redir_type, bus.redir_rs1 == bus.redir_rs2,
                                    bus.redir_rs1[0]);
   assign push        = rsp_in & ~drop_q & ~taken;
   assign pop         = bus.instr_valid & bus.instr_ready;
   assign count_after = count - {1'b0, pop} + {1'b0, push};
   assign slot_free   = (count_after < 2'(BufDepth));

   always_comb begin
      target = bus.redir_rs1;
      case (bus.redir_type)
         JBeq, JBodd: target = bus.redir_pc4 + (bus.redir_imm << 2);
         JJal, JJmp:  target = bus.redir_addr << 2;
         default:     target = bus.redir_rs1;
      endcase
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      drop_d  = drop_q;
      if (taken) begin
         pc_d    = target;
         drop_d  = 1'b0;
         state_d = StReq;
         // An imem request still in flight must be absorbed before refetching at the target.
         if ((state_q == StWait && !bus.imem_rsp_valid) || req_fire) begin
            state_d = StWait;
            drop_d  = 1'b1;
         end
      end else begin
         case (state_q)
            StReq: begin
               if (req_fire) begin
                  state_d = StWait;
                  pc_d    = pc_q + DWIDTH'(4);
               end
            end
            StWait: begin
               if (bus.imem_rsp_valid) begin
                  drop_d  = 1'b0;
                  state_d = slot_free ? StReq : StFull;
               end
            end
            StFull: begin
               if (pop) state_d = StReq;
            end
            default: state_d = StReq;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StReq;
         pc_q        <= RESET_PC;
         drop_q      <= 1'b0;
         req_valid_q <= 1'b0;
         req_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         drop_q      <= drop_d;
         req_valid_q <= (state_d == StReq);
         if (state_d == StReq) req_addr_q <= pc_d;
      end
   end

   assign bus.imem_req_valid = req_valid_q;
   assign bus.imem_req_addr  = req_addr_q;

   // In WAIT, pc_q already holds the outstanding request address + 4.
   fetch_unit_buf #(
      .DWIDTH (DWIDTH)
   ) u_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .push_instr (bus.imem_rsp_data),
      .push_pc4   (pc_q),
      .pop        (pop),
      .flush      (taken),
      .head_instr (bus.instr),
      .head_pc4   (bus.instr_pc4),
      .head_valid (bus.instr_valid),
      .count      (count)
   );

`ifdef FETCH_PERF_EN
   logic [31:0] fetched_q, dropped_q, redirects_q, drop_inc;

   assign drop_inc = 32'(rsp_in & (drop_q | taken)) +
                     (taken ? 32'(count - {1'b0, pop}) : 32'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetched_q   <= '0;
         dropped_q   <= '0;
         redirects_q <= '0;
      end else begin
         fetched_q   <= fetched_q + 32'(push);
         dropped_q   <= dropped_q + drop_inc;
         redirects_q <= redirects_q + 32'(taken);
      end
   end

   assign perf_fetched   = fetched_q;
   assign perf_dropped   = dropped_q;
   assign perf_redirects = redirects_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: the bench plays imem and decode, and a transaction-level model
// (expected PC, outstanding request, queue of deliverable instructions) predicts every output.
module tb_fetch_unit;
   localparam int unsigned DW     = 32;
   localparam logic [31:0] RST_PC = 32'h0;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fetch_unit_if #(.DWIDTH(DW)) bus ();
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched, perf_dropped, perf_redirects;
`endif

   fetch_unit #(
      .DWIDTH   (DW),
      .RESET_PC (RST_PC)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .bus            (bus)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched   (perf_fetched),
      .perf_dropped   (perf_dropped),
      .perf_redirects (perf_redirects)
`endif
   );

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
   } entry_t;

   entry_t      exp_q[$];
   logic [31:0] model_pc, out_addr;
   bit          outstanding, out_dropped;
   int unsigned n_tests, n_fail, n_pops, m_fetched, m_dropped, m_redirects;
   int unsigned pct_req, pct_rsp, pct_ir, pct_redir;
   bit          f_en, f_no_rsp;
   logic [2:0]  f_type;
   logic [31:0] f_pc4, f_imm, f_addr, f_rs1, f_rs2;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
   endfunction

   function automatic bit ref_taken(input logic [2:0] t, input logic [31:0] rs1,
                                    input logic [31:0] rs2);
      case (t)
         3'b001:                 return rs1 == rs2;
         3'b101:                 return rs1[0];
         3'b010, 3'b011, 3'b100: return 1'b1;
         default:                return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] ref_target(input logic [2:0] t, input logic [31:0] pc4,
                                              input logic [31:0] imm, input logic [31:0] addr,
                                              input logic [31:0] rs1);
      case (t)
         3'b001, 3'b101: return pc4 + imm * 32'd4;
         3'b010, 3'b100: return addr * 32'd4;
         default:        return rs1;
      endcase
   endfunction

   task automatic model_reset();
      exp_q.delete();
      model_pc    = RST_PC;
      outstanding = 1'b0;
      out_dropped = 1'b0;
      m_fetched   = 0;
      m_dropped   = 0;
      m_redirects = 0;
   endtask

   task automatic drive_idle();
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      bus.instr_ready    = 1'b0;
      bus.redir_valid    = 1'b0;
      bus.redir_type     = '0;
      bus.redir_pc4      = '0;
      bus.redir_imm      = '0;
      bus.redir_addr     = '0;
      bus.redir_rs1      = '0;
      bus.redir_rs2      = '0;
   endtask

   // Sample on the falling edge, where registered outputs are settled.
   task automatic sample();
      @(negedge clk);
      check("instr_valid", 32'(bus.instr_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         check("instr", bus.instr, exp_q[0].instr);
         check("instr_pc4", bus.instr_pc4, exp_q[0].pc4);
      end
      if (bus.imem_req_valid) begin
         check("req_addr", bus.imem_req_addr, model_pc);
         check("req_slot", 32'(!outstanding && exp_q.size() < 2), 32'd1);
      end
   endtask

   // Drive inputs for the next rising edge and advance the model through that edge.
   task automatic drive();
      bit tk, fire;
      logic [31:0] tgt;
      bus.imem_req_ready = ($urandom_range(99) < pct_req);
      if (outstanding && ($urandom_range(99) < pct_rsp) && !(f_en && f_no_rsp)) begin
         bus.imem_rsp_valid = 1'b1;
         bus.imem_rsp_data  = mem_word(out_addr);
      end else begin
         bus.imem_rsp_valid = 1'b0;
         bus.imem_rsp_data  = $urandom;
      end
      bus.instr_ready = ($urandom_range(99) < pct_ir);
      if (f_en) begin
         bus.redir_valid = 1'b1;
         bus.redir_type  = f_type;
         bus.redir_pc4   = f_pc4;
         bus.redir_imm   = f_imm;
         bus.redir_addr  = f_addr;
         bus.redir_rs1   = f_rs1;
         bus.redir_rs2   = f_rs2;
         f_en = 1'b0;
      end else begin
         bus.redir_valid = ($urandom_range(99) < pct_redir);
         bus.redir_type  = 3'($urandom_range(7));
         bus.redir_pc4   = bus.instr_valid ? bus.instr_pc4 : model_pc;
         bus.redir_imm   = 32'($urandom_range(64)) - 32'd32;
         bus.redir_addr  = $urandom & 32'hFF;
         bus.redir_rs1   = ($urandom & 32'h3FC) | 32'($urandom_range(1));
         bus.redir_rs2   = $urandom_range(1) ? bus.redir_rs1 : (bus.redir_rs1 ^ 32'h4);
      end
      tk   = bus.redir_valid && ref_taken(bus.redir_type, bus.redir_rs1, bus.redir_rs2);
      tgt  = ref_target(bus.redir_type, bus.redir_pc4, bus.redir_imm, bus.redir_addr,
                        bus.redir_rs1);
      fire = bus.imem_req_valid && bus.imem_req_ready;
      if (bus.instr_valid && bus.instr_ready && exp_q.size() != 0) begin
         void'(exp_q.pop_front());
         n_pops++;
      end
      if (bus.imem_rsp_valid) begin
         outstanding = 1'b0;
         if (!out_dropped && !tk) begin
            exp_q.push_back('{instr: mem_word(out_addr), pc4: out_addr + 32'd4});
            m_fetched++;
         end else begin
            m_dropped++;
         end
      end
      if (fire) begin
         outstanding = 1'b1;
         out_dropped = 1'b0;
         out_addr    = model_pc;
         model_pc    = model_pc + 32'd4;
      end
      if (tk) begin
         m_dropped += exp_q.size();
         exp_q.delete();
         if (outstanding) out_dropped = 1'b1;
         model_pc = tgt;
         m_redirects++;
      end
   endtask

   task automatic run(input int n);
      repeat (n) begin
         sample();
         drive();
      end
   endtask

   task automatic set_knobs(input int unsigned rq, input int unsigned rs, input int unsigned ir,
                            input int unsigned rd);
      pct_req = rq; pct_rsp = rs; pct_ir = ir; pct_redir = rd;
   endtask

   task automatic force_redir(input logic [2:0] t, input logic [31:0] pc4, input logic [31:0] imm,
                              input logic [31:0] addr, input logic [31:0] rs1,
                              input logic [31:0] rs2, input bit no_rsp);
      f_en = 1'b1; f_type = t; f_pc4 = pc4; f_imm = imm; f_addr = addr;
      f_rs1 = rs1; f_rs2 = rs2; f_no_rsp = no_rsp;
   endtask

   // Follows a forced taken redirect: buffer empty next cycle, first request at the target.
   task automatic after_redirect(input string tag, input logic [31:0] exp_addr);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         sample();
         if (i == 0) check({tag, "_flush"}, 32'(bus.instr_valid), 32'd0);
         if (bus.imem_req_valid) begin
            check({tag, "_target"}, bus.imem_req_addr, exp_addr);
            done = 1'b1;
         end
         drive();
      end
      if (!done) begin
         n_tests++; n_fail++;
         $display("FAIL %s: no request within 200 cycles", tag);
      end
   endtask

   // Waits (bounded) until the model buffer holds at least `need` entries.
   task automatic wait_entries(input string tag, input int need);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         sample();
         if (exp_q.size() >= need) done = 1'b1;
         else drive();
      end
      if (!done) begin
         n_tests++; n_fail++;
         $display("FAIL %s: buffer never reached %0d entries", tag, need);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_valid"}, 32'(bus.imem_req_valid), 32'd0);
      check({tag, "_req_addr"}, bus.imem_req_addr, 32'd0);
      check({tag, "_instr_valid"}, 32'(bus.instr_valid), 32'd0);
      check({tag, "_instr"}, bus.instr, 32'd0);
      check({tag, "_instr_pc4"}, bus.instr_pc4, 32'd0);
`ifdef FETCH_PERF_EN
      check({tag, "_perf_fetched"}, perf_fetched, 32'd0);
      check({tag, "_perf_dropped"}, perf_dropped, 32'd0);
      check({tag, "_perf_redirects"}, perf_redirects, 32'd0);
`endif
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      n_tests = 0; n_fail = 0; n_pops = 0; f_en = 1'b0; f_no_rsp = 1'b0;
      drive_idle();
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;

      // Streaming fetch with immediate responses and an always-ready decoder.
      set_knobs(100, 100, 100, 0);
      run(20);

      // Decode stalls: buffer fills, FSM stops requesting, then drains in order.
      set_knobs(100, 100, 0, 0);
      run(10);
      sample();
      check("full_no_req", 32'(bus.imem_req_valid), 32'd0);
      check("full_valid", 32'(bus.instr_valid), 32'd1);
      drive();
      set_knobs(100, 100, 100, 0);
      run(10);

      // BEQ taken with two buffered entries.
      set_knobs(100, 100, 0, 0);
      wait_entries("beq_fill", 2);
      force_redir(3'b001, 32'h20, 32'd3, 32'h0, 32'd5, 32'd5, 1'b0);
      drive();
      set_knobs(100, 100, 100, 0);
      after_redirect("beq", 32'h2C);

      // JR while a request is in flight: that response must be dropped.
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         sample();
         if (outstanding && !out_dropped) begin
            force_redir(3'b011, 32'h0, 32'h0, 32'h0, 32'h100, 32'h0, 1'b1);
            found = 1'b1;
         end
         drive();
      end
      check("jr_wait_seen", 32'(found), 32'd1);
      after_redirect("jr", 32'h100);
      run(10);

      // BODD: even rs1 falls through, odd rs1 branches back two words.
      set_knobs(100, 100, 0, 0);
      wait_entries("bodd_fill", 1);
      force_redir(3'b101, 32'h40, 32'hFFFF_FFFE, 32'h0, 32'd2, 32'd0, 1'b0);
      drive();
      sample();
      force_redir(3'b101, 32'h40, 32'hFFFF_FFFE, 32'h0, 32'd3, 32'd0, 1'b0);
      drive();
      set_knobs(100, 100, 100, 0);
      after_redirect("bodd", 32'h38);

      // Randomized traffic with random stalls and redirects.
      set_knobs(60, 60, 70, 8);
      n_pops = 0;
      run(3000);
      check("progress", 32'(n_pops >= 200), 32'd1);
`ifdef FETCH_PERF_EN
      sample();
      check("perf_fetched", perf_fetched, m_fetched);
      check("perf_dropped", perf_dropped, m_dropped);
      check("perf_redirects", perf_redirects, m_redirects);
      drive();
`endif

      // Asynchronous reset while a request is outstanding.
      set_knobs(100, 50, 70, 0);
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         sample();
         if (outstanding) begin
            found = 1'b1;
            rst_n = 1'b0;
            #1;
            check_reset_outputs("async_rst");
            model_reset();
            drive_idle();
            @(negedge clk);
            rst_n = 1'b1;
            sample();
            check("rst_req_valid", 32'(bus.imem_req_valid), 32'd1);
            check("rst_req_addr", bus.imem_req_addr, RST_PC);
         end
         drive();
      end
      check("rst_wait_seen", 32'(found), 32'd1);
      run(30);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
